// File: rtl/draw_scheduler_if.sv
// Pixel path shared by the scheduler: background ROM fetch (address out,
// colour back one cycle later) plus the VGA adapter write port.
interface draw_scheduler_if;
  logic [14:0] bg_addr;
  logic [11:0] bg_colour;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [11:0] colour;
  logic        plot;

  modport master (
    output bg_addr, x, y, colour, plot,
    input  bg_colour
  );

  modport slave (
    input  bg_addr, x, y, colour, plot,
    output bg_colour
  );
endinterface

// File: rtl/draw_scheduler.sv
// Frame scheduler for a single VGA write port. Each frame repaints the
// background from ROM, then draws player 1, player 2 and the ball as solid
// squares, then idles for FRAME_GAP cycles before the next frame.
module draw_scheduler #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int PLAYER_SIZE = 6,
  parameter int BALL_SIZE   = 3,
  parameter int FRAME_GAP   = 2500000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             run,
  input  logic [7:0]       p1_x,
  input  logic [6:0]       p1_y,
  input  logic [7:0]       p2_x,
  input  logic [6:0]       p2_y,
  input  logic [7:0]       ball_x,
  input  logic [6:0]       ball_y,
  output logic             busy,
  output logic             frame_done,
  draw_scheduler_if.master vga
);

  localparam int                WAIT_W      = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(FRAME_GAP - 1);
  localparam logic [7:0]        LAST_COL    = 8'(SCREEN_W - 1);
  localparam logic [6:0]        LAST_ROW    = 7'(SCREEN_H - 1);
  localparam logic [7:0]        PLAYER_LAST = 8'(PLAYER_SIZE - 1);
  localparam logic [7:0]        BALL_LAST   = 8'(BALL_SIZE - 1);
  localparam logic [11:0]       P1_COLOUR   = 12'hF00;
  localparam logic [11:0]       P2_COLOUR   = 12'h00F;
  localparam logic [11:0]       BALL_COLOUR = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    P1,
    P2,
    BALL,
    WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_x_q, cnt_x_d;
  logic [6:0]        cnt_y_q, cnt_y_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        p1_x_q, p1_x_d, p2_x_q, p2_x_d, ball_x_q, ball_x_d;
  logic [6:0]        p1_y_q, p1_y_d, p2_y_q, p2_y_d, ball_y_q, ball_y_d;
  logic [14:0]       bg_addr_q, bg_addr_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [11:0]       colour_q, colour_d;
  logic              plot_q, plot_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [7:0]        spr_x;
  logic [6:0]        spr_y;
  logic [7:0]        span_last;
  logic [11:0]       spr_colour;
  state_t            spr_next;
  logic [8:0]        sum_x;
  logic [7:0]        sum_y;
  logic              clipped;
  logic              start_frame;
  logic [7:0]        nxt_x;
  logic [6:0]        nxt_y;

  // Select the latched position, size, colour and successor of the sprite being drawn.
  always_comb begin
    spr_x      = ball_x_q;
    spr_y      = ball_y_q;
    span_last  = BALL_LAST;
    spr_colour = BALL_COLOUR;
    spr_next   = WAIT;
    case (state_q)
      P1: begin
        spr_x      = p1_x_q;
        spr_y      = p1_y_q;
        span_last  = PLAYER_LAST;
        spr_colour = P1_COLOUR;
        spr_next   = P2;
      end
      P2: begin
        spr_x      = p2_x_q;
        spr_y      = p2_y_q;
        span_last  = PLAYER_LAST;
        spr_colour = P2_COLOUR;
        spr_next   = BALL;
      end
      default: ;
    endcase
    // One extra bit so off-screen pixels are detected instead of wrapping.
    sum_x   = {1'b0, spr_x} + {1'b0, cnt_x_q};
    sum_y   = {1'b0, spr_y} + {1'b0, cnt_y_q};
    clipped = (sum_x >= 9'(SCREEN_W)) || (sum_y >= 8'(SCREEN_H));
  end

  // Next-state, pixel counters, position latching and the next pixel to present.
  always_comb begin
    state_d     = state_q;
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    wait_d      = wait_q;
    p1_x_d      = p1_x_q;
    p1_y_d      = p1_y_q;
    p2_x_d      = p2_x_q;
    p2_y_d      = p2_y_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d     = CLEAR;
          start_frame = 1'b1;
        end
      end

      CLEAR: begin
        // bg_colour already holds the ROM word for the current counter position.
        plot_d   = 1'b1;
        x_d      = cnt_x_q;
        y_d      = cnt_y_q;
        colour_d = vga.bg_colour;
        if (cnt_x_q == LAST_COL) begin
          cnt_x_d = 8'd0;
          if (cnt_y_q == LAST_ROW) begin
            cnt_y_d = 7'd0;
            state_d = P1;
          end else begin
            cnt_y_d = cnt_y_q + 7'd1;
          end
        end else begin
          cnt_x_d = cnt_x_q + 8'd1;
        end
      end

      P1, P2, BALL: begin
        // Clipped pixels still take their cycle; the coordinate outputs hold.
        if (!clipped) begin
          plot_d   = 1'b1;
          x_d      = sum_x[7:0];
          y_d      = sum_y[6:0];
          colour_d = spr_colour;
        end
        if (cnt_x_q == span_last) begin
          cnt_x_d = 8'd0;
          if ({1'b0, cnt_y_q} == span_last) begin
            cnt_y_d = 7'd0;
            state_d = spr_next;
            wait_d  = '0;
          end else begin
            cnt_y_d = cnt_y_q + 7'd1;
          end
        end else begin
          cnt_x_d = cnt_x_q + 8'd1;
        end
      end

      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d = '0;
          if (run) begin
            state_d     = CLEAR;
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      p1_x_d   = p1_x;
      p1_y_d   = p1_y;
      p2_x_d   = p2_x;
      p2_y_d   = p2_y;
      ball_x_d = ball_x;
      ball_y_d = ball_y;
      cnt_x_d  = 8'd0;
      cnt_y_d  = 7'd0;
    end

    frame_done_d = (state_d == WAIT) && (wait_d == WAIT_LAST);
    busy_d       = (state_d != IDLE);
  end

  // Prefetch the ROM one pixel ahead so its one-cycle latency lines up with the
  // registered pixel outputs; outside CLEAR the address parks at 0, ready for (0,0).
  always_comb begin
    if (cnt_x_d == LAST_COL) begin
      nxt_x = 8'd0;
      nxt_y = cnt_y_d + 7'd1;
    end else begin
      nxt_x = cnt_x_d + 8'd1;
      nxt_y = cnt_y_d;
    end
    bg_addr_d = 15'd0;
    if ((state_d == CLEAR) && !((cnt_x_d == LAST_COL) && (cnt_y_d == LAST_ROW))) begin
      bg_addr_d = ({8'd0, nxt_y} * 15'(SCREEN_W)) + {7'd0, nxt_x};
    end
  end

  // State and output registers; reset overrides every other update.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_x_q      <= 8'd0;
      cnt_y_q      <= 7'd0;
      wait_q       <= '0;
      p1_x_q       <= 8'd0;
      p1_y_q       <= 7'd0;
      p2_x_q       <= 8'd0;
      p2_y_q       <= 7'd0;
      ball_x_q     <= 8'd0;
      ball_y_q     <= 7'd0;
      bg_addr_q    <= 15'd0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 12'd0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_x_q      <= cnt_x_d;
      cnt_y_q      <= cnt_y_d;
      wait_q       <= wait_d;
      p1_x_q       <= p1_x_d;
      p1_y_q       <= p1_y_d;
      p2_x_q       <= p2_x_d;
      p2_y_q       <= p2_y_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      bg_addr_q    <= bg_addr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign vga.bg_addr = bg_addr_q;
  assign vga.x       = x_q;
  assign vga.y       = y_q;
  assign vga.colour  = colour_q;
  assign vga.plot    = plot_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: a plain-loop picture model builds the expected
// ordered list of plotted pixels for a frame and the captured plots are
// compared against it, alongside timing, latching, run and reset checks.
module tb_draw_scheduler;

  localparam int GAP       = 4;
  localparam int FRAME_LEN = 19200 + 36 + 36 + 9 + GAP;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] p1_x, p2_x, ball_x;
  logic [6:0] p1_y, p2_y, ball_y;
  logic       busy;
  logic       frame_done;

  draw_scheduler_if vga ();

  draw_scheduler #(.FRAME_GAP(GAP)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .run        (run),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .busy       (busy),
    .frame_done (frame_done),
    .vga        (vga)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Background ROM model: registered read returning the low 12 address bits.
  always @(posedge CLOCK_50) vga.bg_colour <= vga.bg_addr[11:0];

  int tests_run;
  int tests_failed;
  int got_q[$];
  int exp_q[$];
  int first_plot;
  int busy_low;
  int nxt_pos[6];

  task automatic checkOutput(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input int a1x, input int a1y,
                               input int a2x, input int a2y, input int abx, input int aby);
    run    = r;
    p1_x   = 8'(a1x);
    p1_y   = 7'(a1y);
    p2_x   = 8'(a2x);
    p2_y   = 7'(a2y);
    ball_x = 8'(abx);
    ball_y = 7'(aby);
  endtask

  function automatic int packPix(input int px, input int py, input int c);
    return (c << 15) | (py << 8) | px;
  endfunction

  function automatic void addSprite(input int px, input int py, input int size, input int c);
    for (int oy = 0; oy < size; oy++)
      for (int ox = 0; ox < size; ox++)
        if (px + ox < 160 && py + oy < 120) exp_q.push_back(packPix(px + ox, py + oy, c));
  endfunction

  // Expected frame: full background in raster order, then the three sprites.
  function automatic void buildExpected(input int a1x, input int a1y, input int a2x,
                                        input int a2y, input int abx, input int aby);
    exp_q.delete();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        exp_q.push_back(packPix(xx, yy, (yy * 160 + xx) & 'hFFF));
    addSprite(a1x, a1y, 6, 'hF00);
    addSprite(a2x, a2y, 6, 'h00F);
    addSprite(abx, aby, 3, 'hFFF);
  endfunction

  function automatic int findColour(input int px, input int py);
    for (int i = 0; i < got_q.size() && i < 19200; i++)
      if ((got_q[i] & 'h7FFF) == ((py << 8) | px)) return got_q[i] >> 15;
    return -1;
  endfunction

  task automatic compareFrame(input string tag);
    int nbad;
    nbad = 0;
    checkOutput({tag, "_plot_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) nbad++;
    checkOutput({tag, "_pixels_bad"}, nbad, 0);
  endtask

  // Observe one frame cycle by cycle until frame_done; optionally change the
  // positions, drop run or assert reset at given cycle numbers.
  task automatic captureFrame(input int chg_at, input int drop_at, input int rst_at,
                              output int ncyc, output bit done);
    got_q.delete();
    ncyc       = 0;
    done       = 1'b0;
    first_plot = -1;
    busy_low   = 0;
    for (int c = 1; c <= FRAME_LEN + 200; c++) begin
      @(negedge CLOCK_50);
      ncyc = c;
      if (vga.plot) begin
        got_q.push_back(packPix(int'(vga.x), int'(vga.y), int'(vga.colour)));
        if (first_plot < 0) first_plot = c;
      end
      if (!busy) busy_low++;
      if (c == chg_at)
        applyStimulus(run, nxt_pos[0], nxt_pos[1], nxt_pos[2], nxt_pos[3], nxt_pos[4], nxt_pos[5]);
      if (c == drop_at) run = 1'b0;
      if (frame_done) begin
        done = 1'b1;
        break;
      end
      if (c == rst_at) begin
        reset = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  ncyc;
    bit  done;
    int  cnt_a;
    int  cnt_b;
    int  min_x;
    int  rp[6];

    tests_run    = 0;
    tests_failed = 0;

    // Reset state
    reset = 1'b1;
    applyStimulus(1'b0, 10, 80, 140, 80, 78, 60);
    repeat (3) @(negedge CLOCK_50);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_plot", int'(vga.plot), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_x", int'(vga.x), 0);
    checkOutput("rst_y", int'(vga.y), 0);
    checkOutput("rst_colour", int'(vga.colour), 0);
    checkOutput("rst_bg_addr", int'(vga.bg_addr), 0);

    // Nothing happens while run stays low
    reset = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (vga.plot) cnt_a++;
      if (busy) cnt_b++;
    end
    checkOutput("idle_plots", cnt_a, 0);
    checkOutput("idle_busy", cnt_b, 0);

    // Frame 1: reference positions; inputs move mid-CLEAR but must not take effect
    nxt_pos = '{30, 20, 157, 118, 100, 10};
    applyStimulus(1'b1, 10, 80, 140, 80, 78, 60);
    buildExpected(10, 80, 140, 80, 78, 60);
    captureFrame(1000, -1, -1, ncyc, done);
    checkOutput("f1_done_seen", int'(done), 1);
    checkOutput("f1_frame_len", ncyc, FRAME_LEN);
    checkOutput("f1_first_plot_cycle", first_plot, 2);
    checkOutput("f1_busy_low", busy_low, 0);
    checkOutput("f1_first_pixel", (got_q.size() > 0) ? got_q[0] : -1, packPix(0, 0, 0));
    checkOutput("f1_pix_5_1_colour", findColour(5, 1), 165);
    checkOutput("f1_total_plots", got_q.size(), 19200 + 36 + 36 + 9);
    compareFrame("f1");

    // Frame 2: back-to-back, uses the moved positions; run drops mid-BALL
    for (int i = 0; i < 6; i++)
      nxt_pos[i] = (i % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 127));
    buildExpected(30, 20, 157, 118, 100, 10);
    captureFrame(500, 19275, -1, ncyc, done);
    checkOutput("f2_done_seen", int'(done), 1);
    checkOutput("f2_frame_period", ncyc, FRAME_LEN);
    compareFrame("f2");
    cnt_a = 0;
    min_x = 999;
    for (int i = 19200; i < got_q.size(); i++)
      if ((got_q[i] >> 15) == 'h00F) begin
        cnt_a++;
        if ((got_q[i] & 'hFF) < min_x) min_x = got_q[i] & 'hFF;
      end
    checkOutput("f2_p2_plots", cnt_a, 6);
    checkOutput("f2_p2_min_x", min_x, 157);

    // After the frame with run low: back to idle, no more drawing
    @(negedge CLOCK_50);
    checkOutput("stop_busy", int'(busy), 0);
    checkOutput("stop_frame_done", int'(frame_done), 0);
    cnt_a = 0;
    cnt_b = 0;
    repeat (40) begin
      @(negedge CLOCK_50);
      if (vga.plot) cnt_a++;
      if (busy || frame_done) cnt_b++;
    end
    checkOutput("stop_plots", cnt_a, 0);
    checkOutput("stop_activity", cnt_b, 0);

    // Reset mid-CLEAR when the pixel counter sits at (50,30)
    for (int i = 0; i < 6; i++)
      rp[i] = (i % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 127));
    applyStimulus(1'b1, rp[0], rp[1], rp[2], rp[3], rp[4], rp[5]);
    captureFrame(-1, -1, 30 * 160 + 50 + 1, ncyc, done);
    checkOutput("mid_rst_plots_before", got_q.size(), 30 * 160 + 50);
    checkOutput("mid_rst_last_pixel", (got_q.size() > 0) ? got_q[$] : -1,
                packPix(49, 30, (30 * 160 + 49) & 'hFFF));
    @(negedge CLOCK_50);
    checkOutput("mid_rst_plot", int'(vga.plot), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_x", int'(vga.x), 0);
    checkOutput("mid_rst_y", int'(vga.y), 0);
    reset = 1'b0;

    // Frame 3: fresh random frame, reset lands on the edge that would start the final WAIT cycle
    buildExpected(rp[0], rp[1], rp[2], rp[3], rp[4], rp[5]);
    captureFrame(-1, -1, FRAME_LEN - 1, ncyc, done);
    run = 1'b0;
    checkOutput("f3_first_plot_cycle", first_plot, 2);
    checkOutput("f3_done_before_reset", int'(done), 0);
    compareFrame("f3");
    @(negedge CLOCK_50);
    checkOutput("end_rst_frame_done", int'(frame_done), 0);
    checkOutput("end_rst_busy", int'(busy), 0);
    checkOutput("end_rst_plot", int'(vga.plot), 0);
    reset = 1'b0;
    cnt_a = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (frame_done || busy || vga.plot) cnt_a++;
    end
    checkOutput("end_rst_quiet", cnt_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameters (one per line):
- SCREEN_W, 160, pixel columns
- SCREEN_H, 120, pixel rows
- PLAYER_SIZE, 6, player square edge in pixels
- BALL_SIZE, 3, ball square edge in pixels
- FRAME_GAP, 2500000, idle cycles between frames
REQ-002 Ports (one per line):
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = keep drawing frames back to back.
- p1_x / p1_y  in  8 / 7  player 1 top-left position.
- p2_x / p2_y  in  8 / 7  player 2 top-left position.
- ball_x / ball_y  in  8 / 7  ball top-left position.
- bg_addr  out  15  background ROM address.
- bg_colour  in  12  ROM data; valid one cycle after bg_addr.
- x / y  out  8 / 7  pixel coordinate to the VGA adapter.
- colour  out  12  pixel colour to the VGA adapter.
- plot  out  1  pixel write strobe.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-003 The block SHALL share the single VGA write port between four requesters in a fixed order: background, player 1, player 2, ball.
REQ-004 The FSM SHALL have states IDLE, CLEAR, P1, P2, BALL, WAIT.
REQ-005 Transitions:
- IDLE->CLEAR when run=1.
- CLEAR->P1 after pixel (159,119).
- P1->P2 after the last player-1 pixel.
- P2->BALL after the last player-2 pixel.
- BALL->WAIT after the last ball pixel.
- WAIT->CLEAR when FRAME_GAP cycles have elapsed and run=1; WAIT->IDLE when they have elapsed and run=0.
- There SHALL be no bubble cycles between states.
REQ-006 The six position inputs SHALL be latched on the IDLE->CLEAR and WAIT->CLEAR transitions; all sprites in a frame SHALL use the latched values.
REQ-007 CLEAR SHALL scan raster order, x fastest, one pixel per cycle, with bg_addr = y*160 + x computed at 15-bit width.
REQ-008 x, y, colour and plot SHALL be registered and SHALL lag the internal pixel counters by exactly one cycle, so CLEAR colour equals bg_colour for the matching address.
REQ-009 Sprite pixels SHALL be emitted in raster order, one per cycle:
- P1: PLAYER_SIZE² pixels, colour 12'hF00.
- P2: PLAYER_SIZE² pixels, colour 12'h00F.
- BALL: BALL_SIZE² pixels, colour 12'hFFF.
- Coordinates SHALL be the latched position plus the offset, computed one bit wider than the output.
REQ-010 Clipping: a sprite pixel with sum x >= SCREEN_W or y >= SCREEN_H SHALL still consume its cycle with plot=0; no coordinate wrap-around.
REQ-011 plot SHALL be 1 exactly for emitted, unclipped pixels and 0 in IDLE and WAIT.
REQ-012 Per-frame cycle counts:
- plot-high cycles SHALL be 19200 + 2·PLAYER_SIZE² + BALL_SIZE² minus clipped pixels.
- WAIT SHALL last exactly FRAME_GAP cycles.
REQ-013 frame_done SHALL pulse for one cycle on the final WAIT cycle.
REQ-014 run dropping mid-frame SHALL NOT abort the frame; it SHALL only prevent the next frame from starting.

Reset
REQ-015 On reset=1 at a clock edge, the following SHALL take effect the next cycle:
- state=IDLE
- all counters, latched positions, x, y, colour, bg_addr = 0
- plot, busy, frame_done = 0
REQ-016 Reset SHALL win over every other event, including mid-CLEAR and on the same cycle as frame_done.
REQ-017 After reset is released, nothing SHALL be plotted until run=1.

Verification
REQ-018 FRAME_GAP=4, run=1 held, p1=(10,80), p2=(140,80), ball=(78,60), ROM model returns addr[11:0]:
- First plot at (0,0) one cycle after CLEAR entry.
- Pixel (5,1) has colour 165.
- 19200+36+36+9 plots per frame.
- frame_done every 19200+81+4 cycles.
REQ-019 p2=(157,118) -> P2 has 36 cycles but only 6 plot pulses (x 157..159, y 118..119); no plot at x<157.
REQ-020 Positions change mid-CLEAR -> sprites drawn at the values latched at CLEAR entry; new values are used in the next frame.
REQ-021 run=1 then run=0 mid-BALL -> frame completes, frame_done pulses, state=IDLE, busy=0, no further plots.
REQ-022 reset=1 for one cycle mid-CLEAR at pixel (50,30) -> next cycle plot=0, busy=0, x=y=0; with run=1, a fresh frame restarts at (0,0).
REQ-023 Simultaneous reset and final WAIT cycle -> frame_done stays 0, state=IDLE.
